// File: rtl/stream_demux_one_hot_decode.sv
// Binary-to-one-hot decoder: drives exactly one bit of a 2**A-wide vector.
module stream_demux_one_hot_decode #(
    parameter  int unsigned A = 1,
    localparam int unsigned D = 1 << A
) (
    input  logic [A-1:0] bin,
    output logic [D-1:0] one_hot
);

    // Set the single bit addressed by bin.
    always_comb begin
        one_hot      = '0;
        one_hot[bin] = 1'b1;
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-D stream demultiplexer. A packet's channel is captured on
// its first beat and reused for every following beat until in_last.
module stream_demux #(
    parameter  int unsigned A = 1,
    parameter  int unsigned W = 8,
    localparam int unsigned D = 1 << A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] select,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic [D-1:0] out_valid,
    input  logic [D-1:0] out_ready,
    output logic [W-1:0] out_data [D-1:0],
    output logic [D-1:0] out_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic           held;
    logic [A-1:0]   dest;
    logic [A-1:0]   lock_reg;
    logic [W-1:0]   data_q;
    logic           last_q;

    logic [A-1:0]   route;
    logic           accept;
    logic [D-1:0]   dest_oh;

    // The slot frees up in the same cycle its beat drains, so a full
    // downstream sees no bubbles.
    assign in_ready = !held || out_ready[dest];
    assign accept   = in_valid && in_ready;

    // Mid-packet beats follow the channel latched on the first beat.
    always_comb begin
        route = select;
        if (state == LOCKED) begin
            route = lock_reg;
        end
    end

    // Holding register, packet lock and IDLE/LOCKED sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            held     <= 1'b0;
            dest     <= '0;
            lock_reg <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                last_q <= in_last;
                dest   <= route;
                held   <= 1'b1;
            end else if (held && out_ready[dest]) begin
                held   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && !in_last) begin
                        state    <= LOCKED;
                        lock_reg <= select;
                    end
                end
                LOCKED: begin
                    if (accept && in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_demux_one_hot_decode #(
        .A (A)
    ) u_dest_decode (
        .bin     (dest),
        .one_hot (dest_oh)
    );

    // Valid/last appear only on the channel owning the held beat.
    always_comb begin
        out_valid = held ? dest_oh : '0;
        out_last  = (held && last_q) ? dest_oh : '0;
    end

    // Every channel sees the same holding register.
    always_comb begin
        for (int i = 0; i < int'(D); i++) begin
            out_data[i] = data_q;
        end
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-D stream demultiplexer with valid/ready handshake.
- Routes each packet from one input stream to the output channel named by `select`. The channel is sampled at the first beat of the packet and held until the `in_last` beat.
- This is the fan-out counterpart to the N-to-1 recursive mux in basal/misc. It is used to steer AXI-stream-style traffic to D downstream consumers.

Parameters:
- A, 1, select width in bits; must be >= 1.
- W, 8, data width in bits.
- D, 2**A, number of output channels; derived, never overridden.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- select  input  A  destination channel; sampled only on the first beat of a packet.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  W  input payload.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  D  one-hot (or zero) valid per channel.
- out_ready  input  D  per-channel ready.
- out_data  output  W x D (unpacked [W-1:0] out_data [D-1:0])  payload; the same holding register drives every channel.
- out_last  output  D  last flag, asserted only on the active channel.

Behaviour:
- Reset (sync, active-high):
  - held=0, dest=0, data register=0, last register=0, state=IDLE.
  - out_valid=0, out_last=0, out_data=0 on all channels.
  - in_ready=1 on the first cycle after reset.
- Storage: one holding register (data, last, dest, held flag). Latency 1 cycle, input beat to out_valid.
- in_ready = !held || out_ready[dest]; combinational from out_ready.
  - Gives full throughput with no bubbles when downstream is always ready.
- out_valid[i] = held && (dest==i). out_last[i] = held && last && (dest==i).
- Output handshake: the beat leaves when out_valid[dest] && out_ready[dest].
  - If that beat leaves and no new beat is accepted in the same cycle, held clears.
- Accept: in_valid && in_ready loads data/last, sets held, and loads dest from the routing channel.
  - Routing channel = select in IDLE, lock_reg in LOCKED.
- State machine:
  - IDLE: accepting a beat with in_last=0 moves to LOCKED and sets lock_reg=select. Accepting a beat with in_last=1 (single-beat packet) stays in IDLE.
  - LOCKED: select is ignored. Accepting a beat with in_last=1 moves to IDLE. Otherwise stays in LOCKED.
- Simultaneous drain and accept: a new beat may target a different channel than the beat draining.
  - Example: the last beat of a packet on ch1 drains while the first beat of the next packet, targeting ch3, is accepted.
  - dest updates, and out_valid moves from ch1 to ch3 on the next cycle with no gap.
- Stalls:
  - out_ready[i] for i != dest has no effect.
  - While out_ready[dest]=0, the holding register, out_data and out_last stay stable.
  - Changing select mid-packet has no effect.
- in_valid=0: nothing is loaded and the state does not change.
- Reset mid-packet: the held beat is discarded and the state returns to IDLE. The remainder of the packet is not tracked; the next accepted beat starts a new packet.
- A=1 is legal (D=2). No width extension or truncation anywhere; every data path is exactly W bits.

Decomposition:
- State encoding (IDLE/LOCKED) is a local enum. No shared package is needed; A/W/D stay module parameters.
- One natural sub-module: one_hot_decode (A-bit binary to D-bit one-hot), used to generate out_valid/out_last from dest.

Test Plan (A=2, W=8 unless noted):
1. Reset then idle:
   - Stimulus: reset high 2 cycles, then released.
   - Required: out_valid=4'b0000, out_data=0 on all channels, in_ready=1.
2. Single-beat packets, all ready:
   - Stimulus: in_data=8'hA5, last=1, select=2.
   - Required: next cycle out_valid=4'b0100, out_data[2]=8'hA5, out_last=4'b0100.
   - Stimulus: back-to-back with select=0, data=8'h3C.
   - Required: the following cycle out_valid=4'b0001, no bubble.
3. Packet lock:
   - Stimulus: 3-beat packet (8'h01, 8'h02, 8'h03+last), select=1 on beat 0, select changed to 3 on beats 1-2.
   - Required: all three beats appear on ch1 only; out_last=4'b0010 on beat 3.
4. Back-pressure:
   - Stimulus: out_ready[1]=0 while a beat 8'h77 is held for ch1, with out_ready[0,2,3]=1.
   - Required: in_ready=0, out_valid/out_data held stable for 5 cycles.
   - Stimulus: out_ready[1] raised.
   - Required: the beat drains that cycle and in_ready=1.
5. Drain and accept on different channels:
   - Stimulus: last beat of a ch1 packet drains while the first beat 8'hEE is accepted for ch3.
   - Required: next cycle out_valid=4'b1000, out_data[3]=8'hEE.
6. Reset mid-packet:
   - Stimulus: 2 beats of a 4-beat ch2 packet, then reset for 1 cycle, then select=0 with an 8'h55+last beat.
   - Required: out_valid=0 after reset; 8'h55 appears on ch0 (lock cleared).
   - Repeat with A=1 to confirm routing to ch0/ch1.
